// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: state encoding and counter-width helper shared by the divider files.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration (shift, trial subtract, select).
//   p_i/p_o : partial remainder in/out (WIDTH+1 bits)
//   q_i/q_o : dividend/quotient shift register in/out
//   b_i     : divisor magnitude
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   p_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   p_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   s;
    logic [WIDTH+1:0] t;
    // Partial remainder always stays below the divisor, so its top bit is never shifted in.
    logic             unused_p;

    assign unused_p = p_i[WIDTH];

    // t's MSB is the borrow of the trial subtraction.
    always_comb begin
        s   = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
        t   = {1'b0, s} - {2'b0, b_i};
        p_o = t[WIDTH+1] ? s : t[WIDTH:0];
        q_o = {q_i[WIDTH-2:0], ~t[WIDTH+1]};
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
//   clk, reset (async active-low)
//   in_valid/in_ready, dividend, divisor, in_signed : operand handshake
//   out_valid/out_ready, quotient, remainder, div_by_zero : result handshake
//   Define SEQ_DIVIDER_SIGNED_EN to honour in_signed (two's-complement operation).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d, b_q;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_d, rem_d;
    logic [WIDTH-1:0]   quotient_q, remainder_q;
    logic               out_valid_q, in_ready_q, dbz_q;
    logic               accept;

    assign accept      = in_valid && in_ready_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i(p_q),
        .q_i(q_q),
        .b_i(b_q),
        .p_o(p_d),
        .q_o(q_d)
    );

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sa, sb, neg_q, rneg_q;

    assign sa = in_signed && dividend[WIDTH-1];
    assign sb = in_signed && divisor[WIDTH-1];

    // MIN's magnitude wraps to MIN, which read unsigned is exactly |MIN|, so MIN/-1 needs no special case.
    always_comb begin
        a_mag = sa ? -dividend : dividend;
        b_mag = sb ? -divisor : divisor;
        quo_d = neg_q ? -q_d : q_d;
        rem_d = rneg_q ? -p_d[WIDTH-1:0] : p_d[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
        end
`else
    logic unused_signed;

    assign unused_signed = in_signed;

    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        quo_d = q_d;
        rem_d = p_d[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            b_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE:
                    if (accept) begin
                        b_q        <= b_mag;
                        q_q        <= a_mag;
                        p_q        <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            dbz_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                CALC: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE:
                    // Divide-by-zero arrives here with out_valid low; raise it one cycle after accept.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                default: state_q <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and scoreboard-checked bench for seq_divider (WIDTH=16).
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_signed = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .in_signed(in_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a, b;
        logic         s;
        logic [W-1:0] q, r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q, r;
        logic         z;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.q = q; v.r = r; v.z = z;
        return v;
    endfunction

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.z = (b == '0);
        if (b == '0) begin
            v.q = '1;
            v.r = a;
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            v.q = 16'h8000;
            v.r = '0;
        end else if (s) begin
            v.q = 16'($signed(a) / $signed(b));
            v.r = 16'($signed(a) % $signed(b));
        end
`endif
        else begin
            v.q = a / b;
            v.r = a % b;
        end
        return v;
    endfunction

    // Scoreboard: first-valid latency, then result fields on the handshake cycle.
    always @(negedge clk)
        if (reset && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - sb[0].acc, sb[0].lat);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    chk("quotient", {16'd0, quotient}, {16'd0, sb[0].q});
                    chk("remainder", {16'd0, remainder}, {16'd0, sb[0].r});
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, sb[0].z});
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end

    // Presents operands until accepted; w counts edges that passed without acceptance.
    task automatic do_op(input vec_t v, input int lat, input bit push, output int w);
        bit ok;
        w = 0;
        dividend = v.a;
        divisor = v.b;
        in_signed = v.s;
        in_valid = 1'b1;
        forever begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            w++;
            if (w > 200) begin
                chk("accept_timeout", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        if (push) sb.push_back('{v.q, v.r, v.z, lat, cyc});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int w, prev_lat, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        vecs.push_back(mk(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0));
        vecs.push_back(mk(16'hFFFF, 16'd1, 1'b0, 16'hFFFF, 16'd0, 1'b0));
        vecs.push_back(mk(16'h0003, 16'h8000, 1'b0, 16'd0, 16'd3, 1'b0));
        vecs.push_back(mk(16'd5, 16'd0, 1'b0, 16'hFFFF, 16'd5, 1'b1));
        vecs.push_back(mk(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0));
        vecs.push_back(mk(16'hFFF9, 16'd2, 1'b0, 16'h7FFC, 16'd1, 1'b0));
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back(mk(16'hFFF9, 16'd2, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0));
        vecs.push_back(mk(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0, 1'b0));
        vecs.push_back(mk(16'd7, 16'hFFFE, 1'b1, 16'hFFFD, 16'd1, 1'b0));
        vecs.push_back(mk(16'hFFF9, 16'd0, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1));
`else
        vecs.push_back(mk(16'hFFF9, 16'd2, 1'b1, 16'h7FFC, 16'd1, 1'b0));
        vecs.push_back(mk(16'h8000, 16'hFFFF, 1'b1, 16'd0, 16'h8000, 1'b0));
        vecs.push_back(mk(16'd7, 16'hFFFE, 1'b1, 16'd0, 16'd7, 1'b0));
        vecs.push_back(mk(16'hFFF9, 16'd0, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1));
`endif
        for (int i = 0; i < 8; i++)
            vecs.push_back(model(16'($urandom), 16'($urandom) >> $urandom_range(0, 15), 1'($urandom)));

        // Back-to-back: the next op waits L+1 edges (result at L, handshake at L+1, accept at L+2).
        prev_lat = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i], vecs[i].z ? 1 : W, 1'b1, w);
            if (i > 0) chk("accept_wait", w, prev_lat + 1);
            prev_lat = vecs[i].z ? 1 : W;
        end
        drain();

        // Back-pressure: result held, busy, new operands ignored.
        out_ready = 1'b0;
        do_op(mk(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0), W, 1'b1, w);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        dividend = 16'd77;
        divisor = 16'd7;
        in_signed = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_q", {16'd0, quotient}, 32'd100);
            chk("bp_hold_r", {16'd0, remainder}, 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset mid-operation: the aborted op must never present a result.
        do_op(mk(16'd200, 16'd3, 1'b0, 16'd66, 16'd2, 1'b0), W, 1'b0, w);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (W + 4) begin
            @(negedge clk);
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        do_op(mk(16'd200, 16'd3, 1'b0, 16'd66, 16'd2, 1'b0), W, 1'b1, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider: one quotient bit per clock, with a valid/ready handshake on both operands and results.
- Successor to the fixed 16-bit divider datapath. Adds generic width, an internal FSM, divide-by-zero detection, result back-pressure and optional signed division.
- Sits between operand-producing logic and any consumer that can stall.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept operands.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- in_signed  input  1  two's-complement operation; ignored unless the macro is defined.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  divisor was zero for this result.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; counter=0.
  - quotient=0, remainder=0, div_by_zero=0, out_valid=0.
  - in_ready=1 once reset deasserts.
  - A reset mid-operation discards the operation; no result is ever presented.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at an edge:
    - Latch divisor to B.
    - Latch dividend to Q.
    - Clear partial remainder P (WIDTH+1 bits) and counter.
  - If divisor==0, go to DONE and set div_by_zero=1, quotient=all ones, remainder=dividend. out_valid is then high 1 cycle after accept.
  - Otherwise go to CALC.
- CALC (in_ready=0), each edge:
  - S={P[WIDTH-1:0],Q[WIDTH-1]}; T=S-{1'b0,B}.
  - If no borrow: P<=T, Q<={Q[WIDTH-2:0],1}.
  - Otherwise: P<=S, Q<={Q[WIDTH-2:0],0}.
  - counter<=counter+1.
  - The edge on which counter reaches WIDTH-1 performs the last iteration and moves to DONE.
- Latency: out_valid is high exactly WIDTH cycles after the accepting edge (16 for the default).
- DONE:
  - out_valid=1, with quotient=Q, remainder=P[WIDTH-1:0], registered.
  - Outputs are held stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE. in_ready=1 the next cycle; there is no same-cycle accept.
  - quotient, remainder and div_by_zero keep their last values until the next result. Consumers qualify them with out_valid.
- in_valid while busy is ignored. The producer must hold its operands until in_ready.
- Unsigned arithmetic is exact for all inputs: quotient=floor(dividend/divisor), remainder<divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined, and in_signed=1 at accept:
  - Operands are converted to magnitudes before iterating. The sign flags are latched.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - MIN/-1 yields quotient=MIN, remainder=0.
  - Divide by zero yields quotient=all ones, remainder=dividend.
  - Fix-up happens on the DONE entry edge, so latency is unchanged.
- Not defined: in_signed is unused; all operations are unsigned; the sign logic is absent.

Decomposition:
- Package seq_divider_pkg holds:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - A helper function for the CNT_W computation.
- One natural sub-module, div_step: combinational shift/trial-subtract/select for a single iteration, parametrised by WIDTH. It is reusable for a future unrolled divider.
- The FSM, registers and sign fix-up live in seq_divider.

Test Plan:
- WIDTH=16, 100/7, out_ready=1 -> quotient=14, remainder=2, div_by_zero=0; out_valid rises exactly 16 cycles after accept.
- 0xFFFF/1, then 0x0003/0x8000 -> (0xFFFF, 0) then (0, 3); back-to-back operations with in_ready gaps of exactly one cycle.
- 5/0 -> quotient=0xFFFF, remainder=5, div_by_zero=1, out_valid 1 cycle after accept; next op 9/3 -> div_by_zero=0, quotient=3.
- 1000/10 with out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout; a new in_valid in that window is not accepted.
- reset pulsed low 4 cycles into 200/3 -> out_valid never rises for it, in_ready=1 after release; next op 200/3 -> quotient=66, remainder=2.
- Signed macro defined, in_signed=1: -7/2 -> quotient=0xFFFD, remainder=0xFFFF; 0x8000/0xFFFF -> quotient=0x8000, remainder=0; in_signed=0: 0xFFF9/2 -> quotient=0x7FFC, remainder=1.
